// File: rtl/synth_pkg.sv
// Shared types and default timing for the synth front-panel sequencer.
// Cycle constants are derived from the 12 MHz system clock.
package synth_pkg;

  typedef enum logic [2:0] {
    SLEEP,
    WAKE,
    NOTE,
    GAP,
    IDLE
  } seq_state_t;

  localparam int CLOCK_FREQ          = 12_000_000;
  localparam int DEF_NOTE_CYCLES     = CLOCK_FREQ / 10;   // 100 ms
  localparam int DEF_GAP_CYCLES      = CLOCK_FREQ / 100;  // 10 ms
  localparam int DEF_WAKE_CYCLES     = CLOCK_FREQ / 100;  // 10 ms
  localparam int DEF_IDLE_CYCLES     = CLOCK_FREQ;        // 1 s

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Key requests in, voice enables and amplifier control out.
// master = front panel / test side, slave = the sequencer.
interface note_sequencer_if #(
  parameter int NUM_KEYS = 2
);
  logic [NUM_KEYS-1:0] keys;
  logic                arp_mode;
  logic [NUM_KEYS-1:0] voice_en;
  logic                shutdown_b;
  logic                step_pulse;

  modport master (
    output keys, arp_mode,
    input  voice_en, shutdown_b, step_pulse
  );

  modport slave (
    input  keys, arp_mode,
    output voice_en, shutdown_b, step_pulse
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request at or above i_start, wrapping.
// Returns i_start when nothing is requested; callers only use it with a request pending.
module rr_picker #(
  parameter int NUM_KEYS = 2,
  parameter int IW       = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic [NUM_KEYS-1:0] i_req,
  input  logic [IW-1:0]       i_start,
  output logic [IW-1:0]       o_idx
);

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] s, input int k);
    int j;
    j = int'(s) + k;
    if (j >= NUM_KEYS) j = j - NUM_KEYS;
    return IW'(j);
  endfunction

  // Walk from the farthest offset down so the nearest hit overwrites last.
  always_comb begin
    o_idx = i_start;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (i_req[wrap_idx(i_start, k)]) o_idx = wrap_idx(i_start, k);
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Wakes the amplifier, plays held keys as chord or round-robin arpeggio, sleeps after idle.
// All outputs registered: a key change at edge n shows on voice_en/shutdown_b at edge n+2.
module note_sequencer
  import synth_pkg::*;
#(
  parameter int NUM_KEYS    = 2,
  parameter int NOTE_CYCLES = DEF_NOTE_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  note_sequencer_if.slave bus
);

  localparam int CNT_MAX = max_of(max_of(NOTE_CYCLES, GAP_CYCLES),
                                  max_of(WAKE_CYCLES, IDLE_CYCLES));
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  localparam logic [CW-1:0] NOTE_LAST = CW'(NOTE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
  localparam logic [IW-1:0] CUR_INIT  = IW'(NUM_KEYS - 1);

  seq_state_t          r_state, w_next;
  logic [NUM_KEYS-1:0] r_keys_q;
  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_cur, w_start, w_pick, w_cur_nx;
  logic                r_arp, w_arp_nx;
  logic [NUM_KEYS-1:0] r_voice_en, w_voice_en;
  logic                r_shutdown_b, r_step_pulse;
  logic                w_any, w_entry;

  assign w_any   = |r_keys_q;
  assign w_start = (r_cur == CUR_INIT) ? '0 : r_cur + IW'(1);

  rr_picker #(.NUM_KEYS(NUM_KEYS), .IW(IW)) u_picker (
    .i_req   (r_keys_q),
    .i_start (w_start),
    .o_idx   (w_pick)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= SLEEP;
    else     r_state <= w_next;
  end

  // Timer expiry is tested before key changes so that it wins a same-cycle race.
  always_comb begin
    w_next = r_state;
    case (r_state)
      SLEEP: if (w_any) w_next = WAKE;
      WAKE: begin
        if (r_cnt == WAKE_LAST) w_next = w_any ? NOTE : IDLE;
        else if (!w_any)        w_next = IDLE;
      end
      NOTE: begin
        if (r_arp) begin
          if (r_cnt == NOTE_LAST || !r_keys_q[r_cur]) w_next = GAP;
        end else if (!w_any) begin
          w_next = IDLE;
        end
      end
      GAP:  if (r_cnt == GAP_LAST) w_next = w_any ? NOTE : IDLE;
      IDLE: begin
        if (r_cnt == IDLE_LAST) w_next = SLEEP;
        else if (w_any)         w_next = NOTE;
      end
      default: w_next = SLEEP;
    endcase

    w_entry    = (w_next == NOTE) && (r_state != NOTE);
    w_arp_nx   = w_entry ? bus.arp_mode : r_arp;
    w_cur_nx   = w_entry ? w_pick : r_cur;
    w_voice_en = '0;
    if (w_next == NOTE) w_voice_en = w_arp_nx ? (NUM_KEYS'(1) << w_cur_nx) : r_keys_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_keys_q     <= '0;
      r_cnt        <= '0;
      r_cur        <= CUR_INIT;
      r_arp        <= 1'b0;
      r_voice_en   <= '0;
      r_shutdown_b <= 1'b0;
      r_step_pulse <= 1'b0;
    end else begin
      r_keys_q     <= bus.keys;
      // Saturate so a long chord cannot wrap back onto a terminal count.
      if (w_next != r_state) r_cnt <= '0;
      else if (r_cnt != '1)  r_cnt <= r_cnt + CW'(1);
      r_cur        <= w_cur_nx;
      r_arp        <= w_arp_nx;
      r_voice_en   <= w_voice_en;
      r_shutdown_b <= (w_next != SLEEP);
      r_step_pulse <= w_entry;
    end
  end

  assign bus.voice_en   = r_voice_en;
  assign bus.shutdown_b = r_shutdown_b;
  assign bus.step_pulse = r_step_pulse;

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Sequences the synth's tone voices and the audio amplifier from the front-panel keys. It wakes the amplifier before any note sounds and plays held keys either as a chord or as a round-robin arpeggio with silent gaps. It puts the amplifier back into shutdown after an idle timeout. It sits between the key inputs and the per-voice enables of the tone/mixer/PWM datapath, and drives the amplifier's `shutdown_b` pin.

## Interface
Clock is `clk`; reset is `rst`, synchronous and active-high.

Parameters:
- `NUM_KEYS`, 2: number of keys/voices.
- `NOTE_CYCLES`, 1_200_000: arpeggio note length (100 ms at 12 MHz).
- `GAP_CYCLES`, 120_000: silence between arpeggio notes.
- `WAKE_CYCLES`, 120_000: amplifier wake time before first note.
- `IDLE_CYCLES`, 12_000_000: keys-released time before amplifier shutdown.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `keys`  in  NUM_KEYS  held keys, already synchronized; bit i requests voice i.
- `arp_mode`  in  1  0 = chord, 1 = arpeggio; latched on each NOTE entry.
- `voice_en`  out  NUM_KEYS  per-voice enable to the tone datapath (registered).
- `shutdown_b`  out  1  amplifier enable, active-high = running (registered).
- `step_pulse`  out  1  one-cycle pulse on every NOTE entry.

## Operation
- `keys` is registered into `keys_q`. All decisions use `keys_q`.
- State SLEEP: `shutdown_b`=0, `voice_en`=0. Any bit of `keys_q` set → WAKE, counter cleared.
- State WAKE: `shutdown_b`=1, `voice_en`=0, lasts WAKE_CYCLES cycles.
  - At the end, with keys held → NOTE.
  - If all keys are released at any point during WAKE → IDLE.
- State NOTE: `shutdown_b`=1.
  - Chord mode: `voice_en`=`keys_q` every cycle. Stays in NOTE while any key is held; when none is held → IDLE.
  - Arp mode: `voice_en`=onehot(`cur`). After NOTE_CYCLES cycles → GAP. If key `cur` is released mid-note → GAP on the next cycle (early cut).
- State GAP: `voice_en`=0, lasts GAP_CYCLES cycles. Then any key held → NOTE, otherwise → IDLE.
- State IDLE: `shutdown_b`=1, `voice_en`=0.
  - Any key → NOTE directly, with no wake delay.
  - After IDLE_CYCLES cycles with no key → SLEEP.
- Choice of `cur` on each NOTE entry: the first set bit of `keys_q` searching upward from `cur`+1 with wrap-around, with `cur` itself checked last. A single held key therefore repeats with gaps.
  - `cur` resets to NUM_KEYS-1, so the first note is the lowest held index.
- `step_pulse`=1 exactly in the first cycle of each NOTE. In chord mode it does not re-pulse while staying in NOTE.
- Counters are sized to `$clog2` of the largest cycle parameter. Each counter clears on every state entry; no wrap is possible.
- Reset, including mid-note: state SLEEP, `cur`=NUM_KEYS-1, `keys_q`=0, counters 0, `voice_en`=0, `shutdown_b`=0, `step_pulse`=0. Keys held through reset deassertion restart the WAKE sequence.

## Timing
- Key sampled at edge n → `keys_q` at n+1 → state and registered outputs change at n+2.
- From SLEEP: `shutdown_b` rises at n+2. The first `voice_en` bit rises WAKE_CYCLES cycles later.
- From IDLE: `voice_en` rises at n+2.
- An arpeggio period is NOTE_CYCLES+GAP_CYCLES cycles, minus any early cut.
- If keys change in the same cycle a timer expires, the expiry transition wins. The new keys are evaluated by the destination state's rules.

## Structure
- Shared package `synth_pkg`:
  - state enum `seq_state_t` {SLEEP, WAKE, NOTE, GAP, IDLE};
  - default cycle constants, derived from `CLOCK_FREQ`=12_000_000, shared with the test bench.
- One sub-module, `rr_picker`: combinational round-robin first-set-bit search from a start index, with wrap-around. Parameterized by NUM_KEYS.

## Test plan
All scenarios use NUM_KEYS=2, NOTE=8, GAP=2, WAKE=4, IDLE=16.
- Reset mid-note: press `keys`=01 in arp mode, then assert `rst` during NOTE → next edge all outputs 0 and state SLEEP. Release `rst` with key held → `shutdown_b` high again, `voice_en`=01 after 4 cycles.
- Arpeggio: hold `keys`=11, `arp_mode`=1 → `voice_en` sequence 01 (8 cycles), 00 (2), 10 (8), 00 (2), 01 …; `step_pulse` at each 01/10 start.
- Early cut: `keys`=11 arp, release bit 0 during its note → `voice_en`=00 two cycles after the release edge, then only 10 repeats.
- Chord: `keys`=11, `arp_mode`=0 → `voice_en`=11 continuously, one `step_pulse`. Drop to 01 → `voice_en`=01 two cycles later.
- Idle/sleep: release all keys → `voice_en`=00. `shutdown_b` falls after 16 idle cycles; a press during IDLE gives `voice_en` in 2 cycles with no wake delay.
